// File: rtl/rsa_modexp.sv
// rsa_modexp: x^e mod m by left-to-right square-and-multiply over an external Montgomery multiplier.
// Optional MODEXP_SKIP_LEADING_ZEROS_EN adds a SCAN state that skips leading zero exponent bits.
module rsa_modexp #(
  parameter int WIDTH     = 512,
  parameter int EXP_WIDTH = 512
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [WIDTH-1:0]     in_x,
  input  logic [EXP_WIDTH-1:0] in_e,
  input  logic [WIDTH-1:0]     in_m,
  input  logic [WIDTH-1:0]     in_r_mod,
  input  logic [WIDTH-1:0]     in_r2_mod,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     result,
  output logic                 mm_start,
  output logic [WIDTH-1:0]     mm_a,
  output logic [WIDTH-1:0]     mm_b,
  output logic [WIDTH-1:0]     mm_m,
  input  logic [WIDTH-1:0]     mm_result,
  input  logic                 mm_done
);
  localparam int IDX_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(EXP_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE, CONV_IN, SQR, MUL, CONV_OUT, FINISH
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
    , SCAN
`endif
  } state_t;

  state_t               state;
  logic [EXP_WIDTH-1:0] e_r;
  logic [WIDTH-1:0]     acc;
  logic [WIDTH-1:0]     xt;
  logic [IDX_W-1:0]     idx;
  logic                 mm_ack;
  logic                 idx_last;

  // A product is only taken once the issue cycle has passed, so a stray
  // mm_done coinciding with mm_start can never be mistaken for this op's result.
  assign mm_ack   = mm_done && !mm_start;
  assign idx_last = (idx == '0);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      mm_start <= 1'b0;
      mm_a     <= '0;
      mm_b     <= '0;
      mm_m     <= '0;
      e_r      <= '0;
      acc      <= '0;
      xt       <= '0;
      idx      <= '0;
    end else begin
      mm_start <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: if (start) begin
          e_r      <= in_e;
          acc      <= in_r_mod;
          idx      <= IDX_MAX;
          mm_m     <= in_m;
          mm_a     <= in_x;
          mm_b     <= in_r2_mod;
          mm_start <= 1'b1;
          busy     <= 1'b1;
          state    <= CONV_IN;
        end
        CONV_IN: if (mm_ack) begin
          xt <= mm_result;
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
          state <= SCAN;
`else
          mm_a     <= acc;
          mm_b     <= acc;
          mm_start <= 1'b1;
          state    <= SQR;
`endif
        end
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
        SCAN: begin
          if (e_r[idx]) begin
            // Leading one: acc becomes 1*x directly, so this bit costs no multiply.
            acc <= xt;
            mm_a     <= xt;
            mm_start <= 1'b1;
            if (idx_last) begin
              mm_b  <= WIDTH'(1);
              state <= CONV_OUT;
            end else begin
              mm_b  <= xt;
              idx   <= idx - IDX_W'(1);
              state <= SQR;
            end
          end else if (idx_last) begin
            mm_a     <= acc;
            mm_b     <= WIDTH'(1);
            mm_start <= 1'b1;
            state    <= CONV_OUT;
          end else begin
            idx <= idx - IDX_W'(1);
          end
        end
`endif
        SQR: if (mm_ack) begin
          acc      <= mm_result;
          mm_a     <= mm_result;
          mm_start <= 1'b1;
          if (e_r[idx]) begin
            mm_b  <= xt;
            state <= MUL;
          end else if (idx_last) begin
            mm_b  <= WIDTH'(1);
            state <= CONV_OUT;
          end else begin
            mm_b  <= mm_result;
            idx   <= idx - IDX_W'(1);
            state <= SQR;
          end
        end
        MUL: if (mm_ack) begin
          acc      <= mm_result;
          mm_a     <= mm_result;
          mm_start <= 1'b1;
          if (idx_last) begin
            mm_b  <= WIDTH'(1);
            state <= CONV_OUT;
          end else begin
            mm_b  <= mm_result;
            idx   <= idx - IDX_W'(1);
            state <= SQR;
          end
        end
        // Result and done land together so result is valid in the done cycle.
        CONV_OUT: if (mm_ack) begin
          acc    <= mm_result;
          result <= mm_result;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= FINISH;
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
